sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Shares one sram-like master port between the CPU instruction-fetch and data-access requesters. It sits between the CPU core and the sram-like-to-AXI bridge. Data has fixed priority over instruction. Every accepted request's owner is queued so that in-order responses (`data_ok`, `rdata`) are routed back to the correct requester.

## Interface
- `MAX_OUTSTANDING`, default 2: depth of the route FIFO, i.e. maximum accepted-but-unanswered requests.
- `STARVE_LIMIT`, default 4: consecutive data grants, with instruction waiting, before instruction is forced to win. Used only with the guard compiled in.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `inst_req` in 1; `inst_wr` in 1; `inst_size` in 2; `inst_addr` in 32; `inst_wdata` in 32: instruction requester request.
- `inst_rdata` out 32; `inst_addr_ok` out 1; `inst_data_ok` out 1: instruction requester response.
- `data_req` in 1; `data_wr` in 1; `data_strb` in 4; `data_addr` in 32; `data_wdata` in 32: data requester request.
- `data_rdata` out 32; `data_addr_ok` out 1; `data_data_ok` out 1: data requester response.
- `m_req` out 1; `m_wr` out 1; `m_size` out 2; `m_strb` out 4; `m_addr` out 32; `m_wdata` out 32: master port toward the bridge.
- `m_rdata` in 32; `m_addr_ok` in 1; `m_data_ok` in 1: bridge response.
- `arb_err` out 1: sticky; set when `m_data_ok` arrives while the route FIFO is empty.

## Operation
- Handshake: a request is accepted in the cycle where `req & addr_ok`. A response completes in the cycle where `data_ok` is high. The bridge answers in acceptance order.
- FSM states:
  - `ARB_IDLE`: no grant held.
  - `ARB_INST`: grant held for instruction.
  - `ARB_DATA`: grant held for data.
- In `ARB_IDLE` with the FIFO not full, the winner is chosen combinationally:
  - `data_req` wins over `inst_req`.
  - `m_req` is asserted and the winner's fields are muxed onto the master port.
  - If `m_addr_ok` is high that cycle: accept, stay in `ARB_IDLE`.
  - Otherwise go to `ARB_INST` or `ARB_DATA`.
- In `ARB_INST` / `ARB_DATA`:
  - The grant is locked, so master fields track the locked requester only.
  - `m_req` equals that requester's `req`.
  - On `m_addr_ok` go to `ARB_IDLE`.
  - If the requester drops `req`, go to `ARB_IDLE` without accepting.
- `inst_addr_ok = m_addr_ok & grant_inst`. `data_addr_ok = m_addr_ok & grant_data`. The non-granted requester never sees `addr_ok`.
- Field muxing:
  - Instruction: `m_strb = 4'b1111`, `m_size = inst_size`.
  - Data: `m_strb = data_strb`, `m_size` is derived from the strobe popcount: 1 → 0, 2 → 1, otherwise 2.
- Route FIFO:
  - On every accept, push the requester ID (1 bit).
  - On `m_data_ok`, pop the head. Only the head's `data_ok` pulses, and its `rdata = m_rdata`. The other requester sees `data_ok = 0` and `rdata = 0`.
- Full FIFO: `m_req = 0` and no grant is taken, even if a pop happens in the same cycle. There is no combinational path from `m_data_ok` to `m_req`.
- Empty FIFO with `m_data_ok`: nothing is routed and `arb_err` is set.
- Push and pop in the same cycle: both take effect; the count is unchanged.

## Timing
- Request accept: 0 added cycles; the master port is combinational from the winner's inputs.
- Response: 0 added cycles; `data_ok` and `rdata` are combinational from `m_data_ok` / `m_rdata` and the FIFO head.
- Reset values: all outputs are 0, state is `ARB_IDLE`, FIFO is empty, starvation counter is 0, `arb_err` is 0.
- Reset mid-operation: outstanding entries are discarded. Responses arriving after reset set `arb_err`.
- Pointers wrap modulo `MAX_OUTSTANDING`. The count is `$clog2(MAX_OUTSTANDING)+1` bits wide.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - The starvation counter increments on each data accept while `inst_req` is high.
  - It resets on an instruction accept or when `inst_req` is low.
  - When the counter equals `STARVE_LIMIT`, the next `ARB_IDLE` decision gives instruction priority.
- `ARB_STARVE_GUARD_EN` undefined: strict data priority; the counter and `STARVE_LIMIT` logic are absent.

## Structure
- `arb_pkg` holds:
  - the state encoding `arb_state_t` (`ARB_IDLE`, `ARB_INST`, `ARB_DATA`);
  - requester IDs `REQ_INST = 1'b0` and `REQ_DATA = 1'b1`;
  - the strobe-to-size function.
- Sub-module `arb_route_fifo`:
  - parameterised depth, 1-bit payload;
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`;
  - same clock and reset as the arbiter.

## Test plan
- Simultaneous `inst_req` and `data_req` with `m_addr_ok = 1`: data is accepted first, then instruction in the next cycle. Two `m_data_ok` pulses with `m_rdata` = `0xAAAA0000` then `0x11110000` go to `data_rdata` then `inst_rdata`, respectively.
- `m_addr_ok` held low for 3 cycles during an instruction grant while `data_req` rises: `m_addr` stays at `inst_addr` and `data_addr_ok` stays 0 throughout.
- Three back-to-back accepts with `MAX_OUTSTANDING = 2` and no response: the third cycle has `m_req = 0`. After one `m_data_ok`, `m_req` returns in the next cycle.
- Data write with `data_strb = 4'b1100`: `m_strb = 4'b1100` and `m_size = 1`. Instruction read: `m_strb = 4'b1111`.
- `m_data_ok` pulse with the FIFO empty: `arb_err = 1` and stays 1 until `resetn = 0` for one cycle.
- With guard on and `STARVE_LIMIT = 4`, continuous `data_req` and `inst_req`: grants run data, data, data, data, inst, data. With the guard off, instruction is never granted.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the sram-like request arbiter.
// Holds FSM encoding, requester ids and the strobe-to-size mapping.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INST,
    ARB_DATA
  } arb_state_t;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  function automatic logic [1:0] strb_to_size(
    input logic [3:0] strb
  );
    logic [2:0] n;
    n = {2'b0, strb[0]} + {2'b0, strb[1]}
      + {2'b0, strb[2]} + {2'b0, strb[3]};
    case (n)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// One sram-like channel: request fields plus addr/data handshake.
// master drives requests, slave answers them.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, strb, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, strb, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_req_arbiter_route_fifo.sv
// Route FIFO: remembers the owner of each accepted request
// so in-order responses can be steered back.
module arb_route_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Data-over-instruction arbiter onto one sram-like master port.
// Define ARB_STARVE_GUARD_EN to let instruction win after STARVE_LIMIT data grants.
module sram_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic clk,
  input  logic resetn,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master m,
  output logic arb_err
);

  if (MAX_OUTSTANDING < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("sram_req_arbiter: bad parameters");
  end

  arb_state_t state;
  arb_state_t state_n;
  logic       grant_inst;
  logic       grant_data;
  logic       accept;
  logic       full;
  logic       empty;
  logic       head;
  logic       pop;
  logic       inst_first;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign inst_first = inst.req & (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (!inst.req || (accept && grant_inst))
      starve_cnt <= '0;
    else if (accept && grant_data && starve_cnt != SW'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign inst_first = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!full) begin
          if (inst_first)    grant_inst = 1'b1;
          else if (data.req) grant_data = 1'b1;
          else if (inst.req) grant_inst = 1'b1;
        end
        if (grant_inst && !m.addr_ok) state_n = ARB_INST;
        if (grant_data && !m.addr_ok) state_n = ARB_DATA;
      end
      ARB_INST: begin
        grant_inst = ~full;
        if (!inst.req || m.addr_ok) state_n = ARB_IDLE;
      end
      ARB_DATA: begin
        grant_data = ~full;
        if (!data.req || m.addr_ok) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_comb begin
    m.req   = 1'b0;
    m.wr    = 1'b0;
    m.size  = 2'd0;
    m.strb  = 4'd0;
    m.addr  = '0;
    m.wdata = '0;
    if (grant_data) begin
      m.req   = data.req;
      m.wr    = data.wr;
      m.size  = strb_to_size(data.strb);
      m.strb  = data.strb;
      m.addr  = data.addr;
      m.wdata = data.wdata;
    end else if (grant_inst) begin
      m.req   = inst.req;
      m.wr    = inst.wr;
      m.size  = inst.size;
      m.strb  = 4'b1111;
      m.addr  = inst.addr;
      m.wdata = inst.wdata;
    end
  end

  assign accept       = m.req & m.addr_ok;
  assign inst.addr_ok = m.addr_ok & grant_inst;
  assign data.addr_ok = m.addr_ok & grant_data;

  arb_route_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (grant_data ? REQ_DATA : REQ_INST),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  assign pop          = m.data_ok & ~empty;
  assign inst.data_ok = pop & (head == REQ_INST);
  assign data.data_ok = pop & (head == REQ_DATA);
  assign inst.rdata   = inst.data_ok ? m.rdata : '0;
  assign data.rdata   = data.data_ok ? m.rdata : '0;

  // a response with nothing outstanding means the bridge and arbiter disagree
  always_ff @(posedge clk) begin
    if (!resetn)                arb_err <= 1'b0;
    else if (m.data_ok & empty) arb_err <= 1'b1;
  end

endmodule
